// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: FSM state encoding and requester IDs shared by the RAM port arbiter.
// Revision: 1.0
`default_nettype none

package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select for two requesters; round-robin when ARB_ROUND_ROBIN_EN is defined.
// Revision: 1.0
`default_nettype none

module arb_pick
  import ram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);

`ifdef ARB_ROUND_ROBIN_EN
  // A tie goes to whoever was not granted last; a lone request always wins.
  always_comb begin
    winner = REQ_CPU;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = REQ_LDR;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    winner = REQ_CPU;
    if (!req0 && req1) begin
      winner = REQ_LDR;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: req/ack arbiter sharing the single-port 16x4 data RAM between CPU and loader.
// Revision: 1.0 -- optional round-robin via ARB_ROUND_ROBIN_EN (fixed priority otherwise).
`default_nettype none

module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  r0_req,
  input  logic                  r0_rw,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ack,
  output logic [DATA_WIDTH-1:0] r0_rdata,

  input  logic                  r1_req,
  input  logic                  r1_rw,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ack,
  output logic [DATA_WIDTH-1:0] r1_rdata,

  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_datain,
  input  logic [DATA_WIDTH-1:0] mem_dataout
);

  state_t state;
  logic   grant;
  logic   is_write;
  logic   last;
  logic   winner;

  arb_pick u_pick (
    .req0   (r0_req),
    .req1   (r1_req),
    .last   (last),
    .winner (winner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= REQ_LDR;
    end else if (state == IDLE && (r0_req || r1_req)) begin
      last <= winner;
    end
  end
`else
  assign last = REQ_LDR;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= REQ_CPU;
      is_write   <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_datain <= '0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            grant <= winner;
            if (winner == REQ_LDR) begin
              is_write   <= r1_rw;
              mem_rw     <= r1_rw;
              mem_addr   <= r1_addr;
              mem_datain <= r1_wdata;
            end else begin
              is_write   <= r0_rw;
              mem_rw     <= r0_rw;
              mem_addr   <= r0_addr;
              mem_datain <= r0_wdata;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // The RAM commits a write on this edge; the strobe must not outlive it.
          mem_rw <= 1'b0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          if (grant == REQ_LDR) begin
            r1_ack <= 1'b1;
            if (!is_write) r1_rdata <= mem_dataout;
          end else begin
            r0_ack <= 1'b1;
            if (!is_write) r0_rdata <= mem_dataout;
          end
          state <= DONE;
        end
        DONE: begin
          r0_ack <= 1'b0;
          r1_ack <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed self-checking bench with a behavioural 16x4 RAM on the memory port.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_ram_port_arbiter;

  logic       clk;
  logic       rst;
  logic       r0_req, r0_rw, r0_ack;
  logic [3:0] r0_addr, r0_wdata, r0_rdata;
  logic       r1_req, r1_rw, r1_ack;
  logic [3:0] r1_addr, r1_wdata, r1_rdata;
  logic       mem_rw;
  logic [3:0] mem_addr, mem_datain, mem_dataout;

  logic [3:0] ram_mem [16];

  int n_checks;
  int n_errors;
  int wr_cnt;
  int ack0_cnt;
  int ack1_cnt;
  int both_cnt;
  int ord_cnt;
  logic ord [64];

  ram_port_arbiter #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .r0_req      (r0_req),
    .r0_rw       (r0_rw),
    .r0_addr     (r0_addr),
    .r0_wdata    (r0_wdata),
    .r0_ack      (r0_ack),
    .r0_rdata    (r0_rdata),
    .r1_req      (r1_req),
    .r1_rw       (r1_rw),
    .r1_addr     (r1_addr),
    .r1_wdata    (r1_wdata),
    .r1_ack      (r1_ack),
    .r1_rdata    (r1_rdata),
    .mem_rw      (mem_rw),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_dataout (mem_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rw) ram_mem[mem_addr] <= mem_datain;
  end
  assign mem_dataout = ram_mem[mem_addr];

  // Activity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_rw) wr_cnt <= wr_cnt + 1;
    if (r0_ack) ack0_cnt <= ack0_cnt + 1;
    if (r1_ack) ack1_cnt <= ack1_cnt + 1;
    if (r0_ack && r1_ack) both_cnt <= both_cnt + 1;
    if (r0_ack || r1_ack) begin
      ord[ord_cnt[5:0]] <= r1_ack;
      ord_cnt <= ord_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Single access from an idle arbiter; req is held through DONE and dropped one cycle after ack.
  task automatic run_access(input logic id, input logic rw, input logic [3:0] addr,
                            input logic [3:0] wdata, input logic [3:0] exp_rd, input string tag);
    int  n;
    logic got;
    n   = 0;
    got = 1'b0;
    if (id) begin
      r1_req = 1'b1; r1_rw = rw; r1_addr = addr; r1_wdata = wdata;
    end else begin
      r0_req = 1'b1; r0_rw = rw; r0_addr = addr; r0_wdata = wdata;
    end
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      got = id ? r1_ack : r0_ack;
    end
    check({tag, "_acked"}, {31'd0, got}, 32'd1);
    check({tag, "_latency"}, n, 3);
    if (!rw) check({tag, "_rdata"}, id ? r1_rdata : r0_rdata, exp_rd);
    @(negedge clk);
    if (id) r1_req = 1'b0; else r0_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    int   wr0, a0, a1, oc, t0, t1, n;
    logic drop0, drop1;
    n_checks = 0; n_errors = 0;
    wr_cnt = 0; ack0_cnt = 0; ack1_cnt = 0; both_cnt = 0; ord_cnt = 0;
    rst = 1'b1;
    r0_req = 0; r0_rw = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_rw = 0; r1_addr = 0; r1_wdata = 0;

    repeat (3) @(negedge clk);
    check("rst_mem_rw", {31'd0, mem_rw}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_datain", mem_datain, 0);
    check("rst_acks", {r0_ack, r1_ack}, 0);
    check("rst_rdata", {r0_rdata, r1_rdata}, 0);
    rst = 1'b0;
    @(negedge clk);

    // r0 writes A to address 3, cycle by cycle.
    wr0 = wr_cnt; a0 = ack0_cnt;
    r0_req = 1; r0_rw = 1; r0_addr = 4'h3; r0_wdata = 4'hA;
    @(negedge clk);
    check("wr_issue_rw", {31'd0, mem_rw}, 1);
    check("wr_issue_addr", mem_addr, 3);
    check("wr_issue_data", mem_datain, 4'hA);
    check("wr_issue_ack", {31'd0, r0_ack}, 0);
    @(negedge clk);
    check("wr_cap_rw", {31'd0, mem_rw}, 0);
    check("wr_cap_addr", mem_addr, 3);
    check("wr_cap_ack", {31'd0, r0_ack}, 0);
    @(negedge clk);
    check("wr_done_ack0", {31'd0, r0_ack}, 1);
    check("wr_done_ack1", {31'd0, r1_ack}, 0);
    @(negedge clk);
    check("wr_idle_ack0", {31'd0, r0_ack}, 0);
    r0_req = 0;
    repeat (6) @(negedge clk);
    check("wr_single_pulse", wr_cnt - wr0, 1);
    check("wr_single_ack", ack0_cnt - a0, 1);

    // r1 reads back, then cross traffic at the address boundaries.
    a0 = ack0_cnt;
    run_access(1'b1, 1'b0, 4'h3, 4'h0, 4'hA, "r1_rd3");
    check("r1_rd3_no_ack0", ack0_cnt - a0, 0);
    check("r1_rd3_r0_rdata", r0_rdata, 0);
    run_access(1'b1, 1'b1, 4'hF, 4'h5, 4'h0, "r1_wrF");
    run_access(1'b0, 1'b0, 4'hF, 4'h0, 4'h5, "r0_rdF");
    check("r0_rdF_r1_rdata_kept", r1_rdata, 4'hA);
    run_access(1'b0, 1'b1, 4'h0, 4'hC, 4'h0, "r0_wr0");
    run_access(1'b1, 1'b0, 4'h0, 4'h0, 4'hC, "r1_rd0");

    // Simultaneous reads; last grant was r1, so r0 wins under either policy.
    r0_req = 1; r0_rw = 0; r0_addr = 4'h0;
    r1_req = 1; r1_rw = 0; r1_addr = 4'hF;
    t0 = -1; t1 = -1; drop0 = 0; drop1 = 0;
    for (n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (drop0) r0_req = 0;
      if (drop1) r1_req = 0;
      if (r0_ack && t0 < 0) begin t0 = n; drop0 = 1; check("tie_r0_rdata", r0_rdata, 4'hC); end
      if (r1_ack && t1 < 0) begin t1 = n; drop1 = 1; check("tie_r1_rdata", r1_rdata, 4'h5); end
    end
    r0_req = 0; r1_req = 0;
    check("tie_r0_time", t0, 3);
    check("tie_r1_time", t1, 7);
    repeat (2) @(negedge clk);

    // Both requesters hold req continuously for four transactions.
    oc = ord_cnt;
    r0_req = 1; r0_rw = 0; r0_addr = 4'h3;
    r1_req = 1; r1_rw = 0; r1_addr = 4'h3;
    repeat (16) @(negedge clk);
    r0_req = 0; r1_req = 0;
    repeat (4) @(negedge clk);
    check("cont_count", ord_cnt - oc, 4);
`ifdef ARB_ROUND_ROBIN_EN
    check("cont_g0", {31'd0, ord[oc[5:0]]}, 0);
    check("cont_g1", {31'd0, ord[6'(oc + 1)]}, 1);
    check("cont_g2", {31'd0, ord[6'(oc + 2)]}, 0);
    check("cont_g3", {31'd0, ord[6'(oc + 3)]}, 1);
`else
    check("cont_g0", {31'd0, ord[oc[5:0]]}, 0);
    check("cont_g1", {31'd0, ord[6'(oc + 1)]}, 0);
    check("cont_g2", {31'd0, ord[6'(oc + 2)]}, 0);
    check("cont_g3", {31'd0, ord[6'(oc + 3)]}, 0);
`endif

    // Reset while an r1 read sits in CAPTURE.
    a1 = ack1_cnt;
    r1_req = 1; r1_rw = 0; r1_addr = 4'hF;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("rstcap_ack1", {31'd0, r1_ack}, 0);
    check("rstcap_mem_rw", {31'd0, mem_rw}, 0);
    check("rstcap_rdata", r1_rdata, 0);
    rst = 0; r1_req = 0;
    repeat (6) @(negedge clk);
    check("rstcap_no_ack", ack1_cnt - a1, 0);
    run_access(1'b1, 1'b0, 4'hF, 4'h0, 4'h5, "after_rst");

    // Quiet period.
    wr0 = wr_cnt; a0 = ack0_cnt; a1 = ack1_cnt;
    repeat (20) @(negedge clk);
    check("idle_mem_rw", wr_cnt - wr0, 0);
    check("idle_acks", (ack0_cnt - a0) + (ack1_cnt - a1), 0);
    check("never_both_acks", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter for the single-port 16x4 data RAM. It lets the CPU core and a second master (debug/program loader) share the RAM's `rw`/`addr`/`datain`/`dataout` port. It serialises their accesses through a req/ack handshake. It sits between both masters and the `ram` instance, and owns the RAM port outright.

## Interface
- `data_width`, 4, RAM word width
- `addr_width`, 4, RAM address width
- `clk  in  1  clock`; all state changes on its rising edge
- `rst  in  1`; reset is synchronous and active-high
- `r0_req  in  1`; requester 0 (CPU) access request, held until `r0_ack`
- `r0_rw  in  1`; 1 = write, 0 = read
- `r0_addr  in  addr_width`; address
- `r0_wdata  in  data_width`; write data
- `r0_ack  out  1`; one-cycle completion pulse
- `r0_rdata  out  data_width`; read data, valid while `r0_ack` is high
- `r1_req`, `r1_rw`, `r1_addr`, `r1_wdata`, `r1_ack`, `r1_rdata`; identical set for requester 1 (loader)
- `mem_rw  out  1`; to RAM `rw`
- `mem_addr  out  addr_width`; to RAM `addr`
- `mem_datain  out  data_width`; to RAM `datain`
- `mem_dataout  in  data_width`; from RAM `dataout`

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- **IDLE**
  - Sample `r0_req`/`r1_req`.
  - If neither request is high, stay in IDLE.
  - Otherwise pick a winner (see Configuration), register its `rw`/`addr`/`wdata` onto `mem_*`, record the grant index, and go to ISSUE.
- **ISSUE**
  - `mem_rw` equals the winner's `rw`; this is the only state in which `mem_rw` can be 1.
  - The RAM performs the access at the closing edge.
  - Go to CAPTURE.
- **CAPTURE**
  - `mem_rw` is 0 and `mem_addr` is held.
  - At the closing edge:
    - Latch `mem_dataout` into the winner's `rdata` (reads only; the loser's `rdata` is unchanged).
    - Set the winner's `ack` to 1.
  - Go to DONE.
- **DONE**
  - The winner's `ack` is high for exactly this cycle; clear it at the closing edge.
  - Requests are not sampled in DONE, so a requester that drops `req` on the edge after seeing `ack` is never double-served.
  - Go to IDLE.
- Only one `ack` is ever high at a time. The loser's `req` stays pending and is arbitrated on the next IDLE cycle.
- Requester fields must stay stable from `req` rising until `ack`. They are captured only in IDLE, so later changes are ignored.
- The arbiter does no width arithmetic; addresses and data pass through unmodified.

## Timing
- Reset values:
  - State IDLE.
  - `mem_rw` 0, `mem_addr` 0, `mem_datain` 0.
  - `r0_ack`/`r1_ack` 0, `r0_rdata`/`r1_rdata` 0.
  - Round-robin pointer "last granted = 1".
- Latency: `req` sampled high at edge E0 → ISSUE in E0–E1 → RAM access at E1 → `ack` and `rdata` high in the cycle after E2 → IDLE after E3.
- Throughput: one access per 4 cycles. With both requesters continuously requesting, grants alternate (RR) or starve r1 (fixed).
- `req` rising while the FSM is busy is served at the next IDLE; worst-case wait is 4 cycles with RR.
- Reset mid-operation:
  - `rst` high at any edge returns to IDLE and clears the `ack`s and `mem_rw`.
  - A write already driven in ISSUE may still land at that same edge.
  - The interrupted requester gets no `ack` and must re-request.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On a simultaneous request, grant the requester not granted last; the pointer updates on every grant.
  - A lone request is always granted.
- Undefined:
  - Fixed priority; requester 0 always wins a tie.
  - Pointer logic is absent.

## Structure
- Shared package `ram_arb_pkg`: FSM state encoding (IDLE=0, ISSUE=1, CAPTURE=2, DONE=3) and requester IDs (REQ_CPU=0, REQ_LDR=1).
- One sub-module, `arb_pick`:
  - Combinational winner select from the two `req` bits and the last-grant pointer.
  - The pointer is ignored unless `ARB_ROUND_ROBIN_EN` is defined.
- The FSM and the datapath registers live in `ram_port_arbiter`.

## Test plan
- Reset, then r0 writes 4'hA to addr 3 → `mem_rw`=1 for exactly one cycle with `mem_addr`=3 and `mem_datain`=A; `r0_ack` pulses one cycle at edge E2.
- r1 reads addr 3 after that write → `r1_rdata`=4'hA with `r1_ack` high for one cycle; `r0_ack` stays 0.
- r0 and r1 both request reads at the same edge:
  - Fixed build: r0 is served first and r1 follows 4 cycles later.
  - `ARB_ROUND_ROBIN_EN` build: with both held high for 4 transactions, grants are r0, r1, r0, r1.
- Requester holds `req` through DONE and drops it the edge after `ack` → exactly one access is issued (only one `mem_rw` pulse for a write).
- `rst` asserted while in CAPTURE of an r1 read → next cycle IDLE, `r1_ack` never pulses, `mem_rw`=0; after release, a new r1 request completes normally.
- Idle with no requests for 20 cycles → `mem_rw` stays 0 and neither `ack` asserts.
